noc_xy_input_port: RTL
======================

Name: noc_xy_input_port

Overview:
- Parametrised input port for mesh routers: a flit FIFO plus an XY route computer on the head flit, with credit return to the upstream output port.
- Replaces the fixed 16-bit input FIFO and the per-port slice of route logic. One instance per router direction (N/S/E/W/L).
- Its outputs drive the arbiter/crossbar request, and edge routers disable absent directions by parameter.

Parameters:
- DATA_W, 16: flit width in bits; must be ≥ 2*COORD_W.
- DEPTH, 4: FIFO entries; power of two, ≥ 2. Upstream credit counter initialises to this value.
- COORD_W, 4: width of each destination coordinate. dest_x = data[2*COORD_W-1:COORD_W], dest_y = data[COORD_W-1:0].
- XCOORD, 0: this router's X coordinate.
- YCOORD, 0: this router's Y coordinate.
- HAS_N, HAS_S, HAS_E, HAS_W, 1 each: 1 = direction physically present. 0 = edge; routes toward it are errors.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- data_i  in  DATA_W  incoming flit
- write_en_i  in  1  flit valid from upstream
- pop_i  in  1  switch consumed head flit
- data_o  out  DATA_W  head flit
- valid_o  out  1  FIFO non-empty
- route_o  out  5  one-hot requested output {L,W,E,S,N}, bit0 = N
- route_err_o  out  1  head routes to an absent direction
- credit_o  out  1  one-cycle credit return pulse to upstream
- count_o  out  $clog2(DEPTH)+1  current occupancy
- overflow_o  out  1  sticky: write attempted while full

Behaviour:
- Reset (async assert, sync release): FIFO empty, pointers 0, count_o=0, valid_o=0, route_o=0, route_err_o=0, credit_o=0, overflow_o=0. data_o is don't-care while valid_o=0.
- Storage: circular buffer with read/write pointers of $clog2(DEPTH) bits, wrapping DEPTH-1→0, and a separate occupancy counter.
- Write: accepted at a clock edge when write_en_i=1 and (count<DEPTH, or pop accepted in the same cycle).
- Write when full with no pop: flit dropped, count unchanged, overflow_o←1 and held until rst.
- First-word-fall-through: a flit written into an empty FIFO appears on data_o with valid_o=1 the next cycle (latency 1).
- Pop: accepted when pop_i=1 and valid_o=1; the head advances on that edge. pop_i with valid_o=0 is ignored: no credit, no state change.
- Simultaneous write and pop:
  - Both accepted; count unchanged.
  - When empty: the pop is ignored and the write is accepted.
  - When full: both accepted; overflow_o not set.
- Credit: credit_o is registered, =1 in the cycle after each accepted pop. Back-to-back pops give back-to-back pulses. Credits are never issued for dropped writes.
- Route (combinational from head, valid only when valid_o=1; route_o=0 when empty):
  - dest_x > XCOORD → E
  - dest_x < XCOORD → W
  - else dest_y > YCOORD → N
  - else dest_y < YCOORD → S
  - else → L
  - Comparisons are unsigned COORD_W-bit.
- Edge handling: if the selected direction has HAS_*=0, then route_o=0 and route_err_o=1 while that flit is head. The switch must still pop it (drop); the credit is returned normally.
- route_o is exactly one-hot or zero; never multi-hot.
- rst mid-operation: all contents discarded immediately. No credits are issued for discarded flits; upstream resets its counter concurrently.

Optional Feature:
- Macro: NOC_PORT_STATS_EN.
- Defined: adds outputs flits_in_o[15:0] (accepted writes) and flits_drop_o[15:0] (dropped writes). Both reset to 0, increment by 1 per event, and wrap 16'hFFFF→0. A drop counts only in flits_drop_o.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- XCOORD=1,YCOORD=1,DEPTH=4; write 16'h0021 (x=2,y=1) → next cycle valid_o=1, data_o=16'h0021, route_o=5'b00100 (E), count_o=1.
- Write 16'h0011, pop one cycle later → route_o=5'b10000 (L); credit_o=1 exactly in the cycle after the pop; count_o returns to 0, valid_o=0.
- Write 5 flits with no pops → count_o=4, 5th dropped, overflow_o=1 sticky; popping 4 yields flits 1–4 in order and 4 credit pulses.
- Full FIFO, write_en_i and pop_i in the same cycle → count_o stays 4, no overflow; new flit is last out after 4 pops.
- HAS_S=0, write 16'h0010 (x=1,y=0) → route_o=0, route_err_o=1; pop → credit_o pulse, route_err_o=0.
- Assert rst asynchronously with count_o=3 → count_o=0, valid_o=0, credit_o=0 immediately, no credit pulses afterward. With NOC_PORT_STATS_EN: counters read 0.

Source files
------------

// File: rtl/noc_xy_input_port.sv
// noc_xy_input_port: flit FIFO with XY route computation on the head flit and credit return.
// Optional NOC_PORT_STATS_EN adds accepted/dropped flit counters.
module noc_xy_input_port #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 4,
  parameter int XCOORD  = 0,
  parameter int YCOORD  = 0,
  parameter int HAS_N   = 1,
  parameter int HAS_S   = 1,
  parameter int HAS_E   = 1,
  parameter int HAS_W   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       write_en_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       valid_o,
  output logic [4:0]                 route_o,
  output logic                       route_err_o,
  output logic                       credit_o,
  output logic [$clog2(DEPTH):0]     count_o,
`ifdef NOC_PORT_STATS_EN
  output logic [15:0]                flits_in_o,
  output logic [15:0]                flits_drop_o,
`endif
  output logic                       overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [COORD_W-1:0] X = COORD_W'(XCOORD);
  localparam logic [COORD_W-1:0] Y = COORD_W'(YCOORD);
  localparam logic [4:0] PRESENT = {1'b1, HAS_W != 0, HAS_E != 0, HAS_S != 0, HAS_N != 0};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic credit_q, credit_d, overflow_q, overflow_d;
  logic pop_acc, wr_acc, drop;
  logic [COORD_W-1:0] dx, dy;
  logic [4:0] dir;

  always_comb begin
    pop_acc    = pop_i && (count_q != '0);
    wr_acc     = write_en_i && ((count_q != FULL) || pop_acc);
    drop       = write_en_i && !wr_acc;
    rd_ptr_d   = pop_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d   = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d    = count_q + CW'(wr_acc) - CW'(pop_acc);
    credit_d   = pop_acc;
    overflow_d = overflow_q || drop;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end

  // Storage is not reset; contents are only visible while valid_o is high.
  always_ff @(posedge clk)
    if (wr_acc) mem_q[wr_ptr_q] <= data_i;

  always_comb begin
    data_o      = mem_q[rd_ptr_q];
    valid_o     = count_q != '0;
    dx          = data_o[2*COORD_W-1:COORD_W];
    dy          = data_o[COORD_W-1:0];
    dir         = (dx > X) ? 5'b00100 : (dx < X) ? 5'b01000 :
                  (dy > Y) ? 5'b00001 : (dy < Y) ? 5'b00010 : 5'b10000;
    route_o     = valid_o ? (dir & PRESENT) : 5'b0;
    route_err_o = valid_o && |(dir & ~PRESENT);
  end

  assign credit_o   = credit_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

`ifdef NOC_PORT_STATS_EN
  logic [15:0] flits_in_q, flits_in_d, flits_drop_q, flits_drop_d;
  always_comb begin
    flits_in_d   = flits_in_q + 16'(wr_acc);
    flits_drop_d = flits_drop_q + 16'(drop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      flits_in_q   <= '0;
      flits_drop_q <= '0;
    end else begin
      flits_in_q   <= flits_in_d;
      flits_drop_q <= flits_drop_d;
    end
  assign flits_in_o   = flits_in_q;
  assign flits_drop_o = flits_drop_q;
`endif
endmodule
